// File: rtl/sincos_pkg.sv
// Shared types and constants for the sin/cos phase detector.
// Quadrant numbering follows the sign pair (sin, cos): ++ -> 0, +- -> 1, -- -> 2, -+ -> 3.
package sincos_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    SYNC    = 2'd2,
    TRACK   = 2'd3
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int DEF_MID = 128;

  // Channel slots in the packed sample / sign vectors.
  localparam int NUM_CH = 2;
  localparam int CH_SIN = 0;
  localparam int CH_COS = 1;

  function automatic logic [1:0] quad_of(input logic s_sin, input logic s_cos);
    logic [1:0] q;
    case ({s_sin, s_cos})
      2'b11:   q = Q0;
      2'b10:   q = Q1;
      2'b00:   q = Q2;
      default: q = Q3;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/sincos_phase_det_sign_hyst.sv
// Per-channel sign detector with a dead band of +-HYST around MID.
// Exposes the value the sign register takes this cycle so the top can detect crossings with no extra latency.
module sign_hyst
  import sincos_pkg::*;
#(
  parameter int MID  = DEF_MID,
  parameter int HYST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] x,
  output logic       sign_nxt
);

  localparam logic [8:0] HI = 9'(MID + HYST);
  localparam logic [8:0] LO = 9'(MID - HYST);

  logic       sign;
  logic [8:0] xe;

  assign xe = {1'b0, x};

  always_comb begin
    sign_nxt = sign;
    if (en) begin
      if (xe >= HI)      sign_nxt = 1'b1;
      else if (xe <= LO) sign_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sign <= 1'b0;
    else     sign <= sign_nxt;
  end

endmodule

// File: rtl/sincos_phase_det.sv
// Quadrant, direction and period recovery from an offset-binary sin/cos sample stream.
// Lock is declared after two same-kind wrap crossings; skips, reversals and timeouts drop back to ACQUIRE.
module sincos_phase_det
  import sincos_pkg::*;
#(
  parameter int MID   = DEF_MID,
  parameter int HYST  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       q_sin,
  input  logic [7:0]       q_cos,
  output logic [1:0]       quadrant,
  output logic             dir,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             fault
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0][7:0] smp;
  logic [NUM_CH-1:0]      sgn_nxt;

  assign smp = {q_cos, q_sin};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sign_hyst #(
      .MID  (MID),
      .HYST (HYST)
    ) u_hyst (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .x        (smp[g]),
      .sign_nxt (sgn_nxt[g])
    );
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0] per_nxt;
  logic [1:0]       q_new, q_diff;
  logic             dir_nxt, pv_nxt, flt_nxt;
  logic             fwd_wrap, rev_wrap, wrap, same_wrap;
  logic             step_fwd, step_rev, skip, timeout, err;

  // The registered quadrant is the "previous" one; q_new is what this sample makes it.
  assign q_new    = quad_of(sgn_nxt[CH_SIN], sgn_nxt[CH_COS]);
  assign q_diff   = q_new - quadrant;
  assign step_fwd = (q_diff == 2'd1);
  assign step_rev = (q_diff == 2'd3);
  assign skip     = (q_diff == 2'd2);
  assign fwd_wrap = (quadrant == Q3) && (q_new == Q0);
  assign rev_wrap = (quadrant == Q0) && (q_new == Q3);
  assign wrap     = fwd_wrap | rev_wrap;

  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  // Timeout fires on the sample that drives the counter into saturation.
  assign timeout  = !wrap && (cnt_inc == CNT_MAX);

  assign same_wrap = dir ? rev_wrap : fwd_wrap;
  assign err       = skip || (dir ? step_fwd : step_rev) || timeout;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    per_nxt   = period;
    pv_nxt    = 1'b0;
    flt_nxt   = 1'b0;
    if (en) begin
      cnt_nxt = wrap ? '0 : cnt_inc;
      case (state)
        IDLE: state_nxt = ACQUIRE;
        ACQUIRE: begin
          if (skip) begin
            flt_nxt = 1'b1;
          end else if (wrap) begin
            dir_nxt   = rev_wrap;
            state_nxt = SYNC;
          end
        end
        SYNC, TRACK: begin
          // A fault on the same sample as a wrap crossing suppresses the period update.
          if (err) begin
            flt_nxt   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ACQUIRE;
          end else if (same_wrap) begin
            per_nxt   = cnt + 1'b1;
            pv_nxt    = 1'b1;
            state_nxt = TRACK;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      quadrant     <= Q0;
      dir          <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      dir          <= dir_nxt;
      period       <= per_nxt;
      period_valid <= pv_nxt;
      fault        <= flt_nxt;
      if (en) quadrant <= q_new;
    end
  end

  assign locked = (state == TRACK);

endmodule

// File: tb/tb_sincos_phase_det.sv
// Directed bench for sincos_phase_det: synthetic sin/cos revolutions checked every cycle against a rule-level model.
module tb_sincos_phase_det;

  localparam int MID   = 128;
  localparam int HYST  = 4;
  localparam int CNT_W = 16;
  localparam int MAXC  = 65535;
  localparam real PI   = 3.14159265358979;

  logic             clk = 1'b0;
  logic             rst, en;
  logic [7:0]       q_sin, q_cos;
  logic [1:0]       quadrant;
  logic             dir, period_valid, locked, fault;
  logic [CNT_W-1:0] period;

  sincos_phase_det #(.MID(MID), .HYST(HYST), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .q_sin        (q_sin),
    .q_cos        (q_cos),
    .quadrant     (quadrant),
    .dir          (dir),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pv_cnt, flt_cnt, qchg_cnt;

  // Model: phase kept as quadrant index, direction as +1/-1, mode as a small int
  // (0 idle, 1 hunting for a wrap, 2 one wrap seen, 3 locked).
  int m_pos_sin, m_pos_cos, m_q, m_step, m_per, m_pv, m_flt, m_mode, m_cnt;
  int qtab[4] = '{2, 3, 1, 0};

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos_sin = 0; m_pos_cos = 0; m_q = 0; m_step = 1; m_per = 0;
    m_pv = 0; m_flt = 0; m_mode = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    int nq, mv, ncnt;
    bit crossed, bad;
    if (rst) begin
      model_reset();
      return;
    end
    m_pv = 0;
    m_flt = 0;
    if (!en) return;
    if (int'(q_sin) >= MID + HYST) m_pos_sin = 1;
    else if (int'(q_sin) <= MID - HYST) m_pos_sin = 0;
    if (int'(q_cos) >= MID + HYST) m_pos_cos = 1;
    else if (int'(q_cos) <= MID - HYST) m_pos_cos = 0;
    nq = qtab[m_pos_sin * 2 + m_pos_cos];
    // signed movement: -1, 0, +1, or 2 for a skip
    mv = (nq - m_q + 4) % 4;
    if (mv == 3) mv = -1;
    crossed = (m_q == 3 && nq == 0) || (m_q == 0 && nq == 3);
    ncnt = crossed ? 0 : ((m_cnt < MAXC) ? m_cnt + 1 : MAXC);
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (mv == 2) m_flt = 1;
      else if (crossed) begin
        m_step = mv;
        m_mode = 2;
      end
    end else begin
      bad = (mv == 2) || (mv == -m_step) || (!crossed && ncnt == MAXC);
      if (bad) begin
        m_flt = 1;
        ncnt = 0;
        m_mode = 1;
      end else if (crossed && mv == m_step) begin
        m_per = m_cnt + 1;
        m_pv = 1;
        m_mode = 3;
      end
    end
    m_cnt = ncnt;
    m_q = nq;
  endtask

  task automatic compare_model();
    chk("quadrant", int'(quadrant), m_q);
    chk("dir", int'(dir), (m_step < 0) ? 1 : 0);
    chk("period", int'(period), m_per);
    chk("period_valid", int'(period_valid), m_pv);
    chk("locked", int'(locked), (m_mode == 3) ? 1 : 0);
    chk("fault", int'(fault), m_flt);
  endtask

  task automatic drive(input bit r, input bit e, input int s, input int c);
    int q_before;
    q_before = int'(quadrant);
    rst = r; en = e; q_sin = 8'(s); q_cos = 8'(c);
    @(posedge clk);
    #1;
    model_step();
    @(negedge clk);
    compare_model();
    if (period_valid) pv_cnt++;
    if (fault) flt_cnt++;
    if (int'(quadrant) != q_before) qchg_cnt++;
  endtask

  function automatic int wave(input int n, input bit is_cos);
    real ph, v;
    ph = 2.0 * PI * real'(n % 256) / 256.0;
    v = is_cos ? $cos(ph) : $sin(ph);
    return 128 + int'(127.0 * v);
  endfunction

  function automatic int jitter(input int x, input int n, input int k);
    int d;
    d = x - 128;
    if (d >= -8 && d <= 8) return x + (((n % 256) * k) % 5) - 2;
    return x;
  endfunction

  task automatic run_stream(input int n0, input int n1, input bit neg_cos, input bit noisy);
    int s, c;
    for (int n = n0; n < n1; n++) begin
      s = wave(n, 1'b0);
      c = wave(n, 1'b1);
      if (neg_cos) c = 255 - c;
      if (noisy) begin
        s = jitter(s, n, 3);
        c = jitter(c, n, 7);
      end
      drive(1'b0, 1'b1, s, c);
    end
  endtask

  task automatic clear_counts();
    pv_cnt = 0; flt_cnt = 0; qchg_cnt = 0;
  endtask

  initial begin
    model_reset();
    clear_counts();
    rst = 1'b1; en = 1'b0; q_sin = '0; q_cos = '0;

    // reset with random inputs
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'(i[0]), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    chk("rst_quadrant", int'(quadrant), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_pv", int'(period_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_fault", int'(fault), 0);

    // forward revolutions
    drive(1'b1, 1'b0, 0, 0);
    clear_counts();
    run_stream(0, 768, 1'b0, 1'b0);
    chk("fwd_locked", int'(locked), 1);
    chk("fwd_dir", int'(dir), 0);
    chk("fwd_period", int'(period), 256);
    chk("fwd_pv_count", pv_cnt, 2);
    chk("fwd_faults", flt_cnt, 0);

    // reverse: cos negated
    drive(1'b1, 1'b0, 0, 0);
    clear_counts();
    run_stream(0, 768, 1'b1, 1'b0);
    chk("rev_locked", int'(locked), 1);
    chk("rev_dir", int'(dir), 1);
    chk("rev_period", int'(period), 256);
    chk("rev_pv_count", pv_cnt, 2);

    // +-2 LSB noise near each zero crossing
    drive(1'b1, 1'b0, 0, 0);
    clear_counts();
    run_stream(0, 256, 1'b0, 1'b1);
    qchg_cnt = 0;
    run_stream(256, 768, 1'b0, 1'b1);
    chk("noise_qchanges", qchg_cnt, 8);
    chk("noise_faults", flt_cnt, 0);
    chk("noise_period", int'(period), 256);
    chk("noise_locked", int'(locked), 1);

    // forced 0->2 jump while tracking, then re-lock
    drive(1'b1, 1'b0, 0, 0);
    clear_counts();
    run_stream(0, 788, 1'b0, 1'b0);
    chk("pre_jump_locked", int'(locked), 1);
    drive(1'b0, 1'b1, 0, 0);
    chk("jump_fault", int'(fault), 1);
    chk("jump_locked", int'(locked), 0);
    run_stream(789, 1400, 1'b0, 1'b0);
    chk("relock_locked", int'(locked), 1);
    chk("relock_period", int'(period), 256);

    // en low mid-revolution
    clear_counts();
    for (int i = 0; i < 100; i++)
      drive(1'b0, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    chk("enlow_pulses", pv_cnt + flt_cnt, 0);
    run_stream(1400, 1800, 1'b0, 1'b0);
    chk("enlow_period", int'(period), 256);
    chk("enlow_pv_count", pv_cnt, 2);
    chk("enlow_locked", int'(locked), 1);

    // constant input until timeout
    clear_counts();
    for (int i = 0; i < MAXC; i++)
      drive(1'b0, 1'b1, wave(1799, 1'b0), wave(1799, 1'b1));
    chk("timeout_faults", flt_cnt, 1);
    chk("timeout_locked", int'(locked), 0);
    chk("timeout_period_held", int'(period), 256);

    // reset while tracking
    drive(1'b1, 1'b0, 0, 0);
    run_stream(0, 600, 1'b0, 1'b0);
    chk("pre_rst_locked", int'(locked), 1);
    drive(1'b1, 1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    chk("midrst_quadrant", int'(quadrant), 0);
    chk("midrst_period", int'(period), 0);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_dir", int'(dir), 0);
    drive(1'b0, 1'b1, 200, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
